// File: rtl/dsp_mac_seq.sv
// dsp_mac_seq: streaming dot-product sequencer acting as initiator for one DSP48A1 slice.
// Issues A/B and per-beat OPMODE, waits out the slice latency, then returns the P sum.
module dsp_mac_seq #(
  parameter int OPM_DLY = 1,
  parameter int DSP_LAT = 4
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic signed [17:0] s_a,
  input  logic signed [17:0] s_b,
  input  logic               s_last,
  output logic signed [17:0] A,
  output logic signed [17:0] B,
  output logic        [17:0] D,
  output logic        [47:0] C,
  output logic               CARRYIN,
  output logic        [7:0]  OPMODE,
  output logic               CE,
  input  logic        [47:0] P,
  output logic               m_valid,
  input  logic               m_ready,
  output logic        [47:0] m_data,
  output logic        [15:0] m_count
);

  localparam int            CW         = (DSP_LAT > 1) ? $clog2(DSP_LAT) : 1;
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(DSP_LAT - 1);

  localparam logic [7:0] OPM_ZERO  = 8'h00;
  localparam logic [7:0] OPM_FIRST = 8'h01;
  localparam logic [7:0] OPM_ACC   = 8'h09;
  localparam logic [7:0] OPM_HOLD  = 8'h08;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic                    s_ready_q, s_ready_d;
  logic signed [17:0]      a_q, a_d;
  logic signed [17:0]      b_q, b_d;
  // Stage 0 is aligned with A/B; stage OPM_DLY drives OPMODE.
  logic [OPM_DLY:0][7:0]   opm_q, opm_d;
  logic [7:0]              beat_opm_s;
  logic                    accept_s;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [15:0]             pairs_q, pairs_d;
  logic                    m_valid_q, m_valid_d;
  logic [47:0]             m_data_q, m_data_d;
  logic [15:0]             m_count_q, m_count_d;
  logic                    ce_q, ce_d;

  assign accept_s = s_valid && s_ready_q;

  // Next-state, beat opcode and result capture.
  always_comb begin
    state_d    = state_q;
    a_d        = 18'sd0;
    b_d        = 18'sd0;
    beat_opm_s = OPM_HOLD;
    cnt_d      = cnt_q;
    pairs_d    = pairs_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    m_count_d  = m_count_q;
    ce_d       = 1'b1;

    if (accept_s) begin
      a_d = s_a;
      b_d = s_b;
      if (state_q == ST_IDLE) begin
        pairs_d = 16'd1;
      end else if (pairs_q != 16'hFFFF) begin
        pairs_d = pairs_q + 16'd1;
      end else begin
        pairs_d = pairs_q;
      end
    end else begin
      pairs_d = pairs_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          beat_opm_s = OPM_FIRST;
          if (s_last) begin
            state_d = ST_DRAIN;
            cnt_d   = DRAIN_LOAD;
          end else begin
            state_d = ST_ACCUM;
          end
        end else begin
          beat_opm_s = OPM_ZERO;
        end
      end
      ST_ACCUM: begin
        if (accept_s) begin
          beat_opm_s = OPM_ACC;
          if (s_last) begin
            state_d = ST_DRAIN;
            cnt_d   = DRAIN_LOAD;
          end else begin
            state_d = ST_ACCUM;
          end
        end else begin
          beat_opm_s = OPM_HOLD;
        end
      end
      ST_DRAIN: begin
        // P for the last beat is stable once the counter has run down.
        if (cnt_q == '0) begin
          state_d   = ST_OUT;
          m_valid_d = 1'b1;
          m_data_d  = P;
          m_count_d = pairs_q;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_OUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    s_ready_d = (state_d == ST_IDLE) || (state_d == ST_ACCUM);

    opm_d[0] = beat_opm_s;
    for (int i = 1; i <= OPM_DLY; i++) begin
      opm_d[i] = opm_q[i-1];
    end
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      s_ready_q <= 1'b0;
      a_q       <= 18'sd0;
      b_q       <= 18'sd0;
      opm_q     <= {(OPM_DLY + 1){OPM_ZERO}};
      cnt_q     <= '0;
      pairs_q   <= 16'd0;
      m_valid_q <= 1'b0;
      m_data_q  <= 48'd0;
      m_count_q <= 16'd0;
      ce_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= s_ready_d;
      a_q       <= a_d;
      b_q       <= b_d;
      opm_q     <= opm_d;
      cnt_q     <= cnt_d;
      pairs_q   <= pairs_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_count_q <= m_count_d;
      ce_q      <= ce_d;
    end
  end

  assign s_ready = s_ready_q;
  assign A       = a_q;
  assign B       = b_q;
  assign D       = 18'd0;
  assign C       = 48'd0;
  assign CARRYIN = 1'b0;
  assign OPMODE  = opm_q[OPM_DLY];
  assign CE      = ce_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_count = m_count_q;

endmodule

// File: tb/tb_dsp_mac_seq.sv
// Bench for dsp_mac_seq: drives it against a behavioural DSP48A1 slice model and
// scores results against a dot-product reference kept as plain integer sums.
module tb_dsp_mac_seq;

  logic               CLK = 1'b0;
  logic               RST_N;
  logic               s_valid, s_ready, s_last;
  logic signed [17:0] s_a, s_b;
  logic signed [17:0] A, B;
  logic        [17:0] D;
  logic        [47:0] C;
  logic               CARRYIN, CE;
  logic        [7:0]  OPMODE;
  logic        [47:0] P;
  logic               m_valid, m_ready;
  logic        [47:0] m_data;
  logic        [15:0] m_count;

  always #5 CLK = ~CLK;

  dsp_mac_seq #(.OPM_DLY(1), .DSP_LAT(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_last(s_last),
    .A(A), .B(B), .D(D), .C(C), .CARRYIN(CARRYIN), .OPMODE(OPMODE), .CE(CE), .P(P),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_count(m_count)
  );

  // DSP48A1 slice, default pipeline: A1/B1, M, OPMODE and P registers.
  logic signed [17:0] a1_r = '0, b1_r = '0;
  logic signed [35:0] m_r = '0;
  logic        [7:0]  opm_r = '0;
  logic        [47:0] p_r = '0;
  always @(posedge CLK) begin
    if (CE) begin
      a1_r  <= A;
      b1_r  <= B;
      m_r   <= a1_r * b1_r;
      opm_r <= OPMODE;
      case (opm_r)
        8'h00:   p_r <= 48'd0;
        8'h01:   p_r <= {{12{m_r[35]}}, m_r};
        8'h09:   p_r <= p_r + {{12{m_r[35]}}, m_r};
        default: p_r <= p_r;
      endcase
    end
  end
  assign P = p_r;

  typedef struct { logic [47:0] d; logic [15:0] c; } res_t;
  res_t exp_q[$];

  int     errors = 0;
  int     checks = 0;
  longint ref_sum = 0;
  int     ref_cnt = 0;
  bit     ref_open = 1'b0;
  bit     rand_ready = 1'b0;
  logic [47:0] last_d = '0;
  logic [15:0] last_c = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present one pair, wait for acceptance, fold it into the reference sum.
  task automatic beat(input int a, input int b, input logic last);
    int g;
    s_valid = 1'b1;
    s_a     = 18'(a);
    s_b     = 18'(b);
    s_last  = last;
    g = 0;
    while (!s_ready && g < 100) begin
      tick();
      g++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: s_ready stayed 0 for %0d cycles", g);
    end else begin
      tick();
      if (!ref_open) begin
        ref_sum  = 0;
        ref_cnt  = 0;
        ref_open = 1'b1;
      end
      ref_sum = ref_sum + longint'(a) * longint'(b);
      if (ref_cnt < 65535) ref_cnt++;
      if (last) begin
        exp_q.push_back('{d: ref_sum[47:0], c: 16'(ref_cnt)});
        ref_open = 1'b0;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 300) begin
      tick();
      g++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results still pending", exp_q.size());
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_s_ready"}, s_ready, 1'b0);
    chk({tag, "_ab"}, {A, B}, 36'd0);
    chk({tag, "_opmode"}, OPMODE, 8'h00);
    chk({tag, "_ce"}, CE, 1'b0);
    chk({tag, "_m_valid"}, m_valid, 1'b0);
    chk({tag, "_m_data"}, m_data, 48'd0);
    chk({tag, "_m_count"}, m_count, 16'd0);
  endtask

  always @(posedge CLK) begin
    #1;
    if (rand_ready) m_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: pops the scoreboard on each handshake and checks stall stability.
  logic        prev_hold = 1'b0;
  logic [47:0] prev_d = '0;
  logic [15:0] prev_c = '0;
  always @(negedge CLK) begin
    if (!RST_N) begin
      prev_hold <= 1'b0;
    end else begin
      if (prev_hold) begin
        chk("stall_valid", m_valid, 1'b1);
        chk("stall_data", m_data, prev_d);
        chk("stall_count", m_count, prev_c);
        chk("stall_s_ready", s_ready, 1'b0);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: m_data %0h with nothing expected", m_data);
        end else begin
          chk("result_data", m_data, exp_q[0].d);
          chk("result_count", m_count, exp_q[0].c);
          void'(exp_q.pop_front());
          last_d <= m_data;
          last_c <= m_count;
        end
      end
      prev_hold <= m_valid && !m_ready;
      prev_d    <= m_data;
      prev_c    <= m_count;
    end
  end

  initial begin
    int n;
    int len;
    RST_N   = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_a     = '0;
    s_b     = '0;
    m_ready = 1'b0;
    #2 RST_N = 1'b0;
    repeat (3) tick();
    chk_reset_vals("rst");
    chk("rst_tieoffs", {D, C, CARRYIN}, 67'd0);
    RST_N = 1'b1;
    tick();
    chk("post_rst_s_ready", s_ready, 1'b1);
    chk("post_rst_ce", CE, 1'b1);

    // Three pairs back to back; latency from last acceptance to m_valid.
    m_ready = 1'b1;
    beat(3, 4, 1'b0);
    beat(5, 6, 1'b0);
    beat(-2, 7, 1'b1);
    n = 0;
    while (!m_valid && n < 20) begin
      tick();
      n++;
    end
    chk("t1_latency", n, 4);
    chk("t1_data", m_data, 48'd28);
    chk("t1_count", m_count, 16'd3);
    wait_drain();

    // Single-pair vector from IDLE: FIRST then HOLD on OPMODE.
    tick();
    beat(-131072, -131072, 1'b1);
    tick();
    chk("t2_opm_first", OPMODE, 8'h01);
    tick();
    chk("t2_opm_hold", OPMODE, 8'h08);
    wait_drain();
    chk("t2_data", last_d, 48'h000400000000);
    chk("t2_count", last_c, 16'd1);

    // Bubbles inside a vector.
    beat(10, 20, 1'b0);
    tick();
    chk("t3_bubble1_ab", {A, B}, 36'd0);
    chk("t3_bubble1_opm", OPMODE, 8'h01);
    tick();
    chk("t3_bubble2_ab", {A, B}, 36'd0);
    chk("t3_bubble2_opm", OPMODE, 8'h08);
    beat(1, 1, 1'b1);
    wait_drain();
    chk("t3_data", last_d, 48'd201);

    // Back-pressure on the result port, next vector waiting.
    m_ready = 1'b0;
    beat(3, 4, 1'b0);
    beat(5, 6, 1'b0);
    beat(-2, 7, 1'b1);
    n = 0;
    while (!m_valid && n < 20) begin
      tick();
      n++;
    end
    s_valid = 1'b1;
    s_a = 18'sd2;
    s_b = 18'sd3;
    s_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", m_valid, 1'b1);
      chk("t4_hold_data", m_data, 48'd28);
      chk("t4_hold_s_ready", s_ready, 1'b0);
      tick();
    end
    m_ready = 1'b1;
    beat(2, 3, 1'b1);
    wait_drain();
    chk("t4_next_data", last_d, 48'd6);

    // Asynchronous reset mid-vector.
    beat(1, 2, 1'b0);
    beat(3, 4, 1'b0);
    s_valid = 1'b1;
    s_a = 18'sd5;
    s_b = 18'sd6;
    s_last = 1'b1;
    #2 RST_N = 1'b0;
    #1;
    chk_reset_vals("midrst");
    s_valid  = 1'b0;
    s_last   = 1'b0;
    ref_open = 1'b0;
    repeat (2) tick();
    RST_N = 1'b1;
    tick();
    beat(1, 1, 1'b0);
    beat(2, 2, 1'b1);
    wait_drain();
    chk("t5_data", last_d, 48'd5);
    chk("t5_count", last_c, 16'd2);

    // Largest positive products, eight in a row.
    for (int i = 0; i < 8; i++) beat(131071, 131071, i == 7);
    wait_drain();
    chk("t6_data", last_d, 48'h1FFFE00008);
    chk("t6_count", last_c, 16'd8);

    // Random vectors, gaps with stray s_last, random result back-pressure.
    rand_ready = 1'b1;
    for (int v = 0; v < 30; v++) begin
      len = int'($urandom_range(1, 8));
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 3) == 0) begin
          s_last = 1'($urandom_range(0, 1));
          repeat ($urandom_range(1, 2)) tick();
          s_last = 1'b0;
        end
        beat(int'($urandom_range(0, 262143)) - 131072,
             int'($urandom_range(0, 262143)) - 131072, j == len - 1);
      end
    end
    wait_drain();
    rand_ready = 1'b0;
    repeat (2) tick();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
